// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory request lines into the stall controller and the per-stage
// register enable / bubble controls it returns.
interface pipeline_stall_ctrl_if;
    logic load_use_stall;
    logic redirect_valid;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_flush;

    modport master (
        output load_use_stall, redirect_valid, imem_ready, dmem_req, dmem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_flush
    );

    modport slave (
        input  load_use_stall, redirect_valid, imem_ready, dmem_req, dmem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_flush
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: converts hazards and memory
// wait states into stage enables/bubbles, tracks wrong-path fetch drain.
module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cnt_clr,
    pipeline_stall_ctrl_if.slave   bus,
    output logic [1:0]             state_o,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        DMEM_WAIT   = 2'd1,
        FETCH_DRAIN = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze, drain_pend, redirect_acc;

    assign freeze     = bus.dmem_req & ~bus.dmem_ready;
    assign drain_pend = (state_q == FETCH_DRAIN) & ~bus.imem_ready;

    always_comb begin
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.mem_wb_en    = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.mem_wb_flush = 1'b0;
        redirect_acc     = 1'b0;
        state_d          = RUN;

        if (!rst_n) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_en    = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else if (freeze) begin
            // Only MEM/WB advances (as a bubble); a pending drain survives the freeze.
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_flush = 1'b1;
            state_d          = drain_pend ? FETCH_DRAIN : DMEM_WAIT;
        end else if (bus.redirect_valid) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            redirect_acc     = 1'b1;
            state_d          = bus.imem_ready ? RUN : FETCH_DRAIN;
        end else if (state_q == FETCH_DRAIN) begin
            bus.pc_en        = 1'b0;
            bus.if_id_flush  = 1'b1;
            state_d          = bus.imem_ready ? RUN : FETCH_DRAIN;
        end else if (bus.load_use_stall) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_flush  = 1'b1;
        end else if (!bus.imem_ready) begin
            bus.pc_en        = 1'b0;
            bus.if_id_flush  = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!rst_n || cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!bus.pc_en && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (redirect_acc && flush_cnt_q != CNT_MAX)
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign state_o   = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed vectors for pipeline_stall_ctrl; expected outputs are queued per
// cycle and checked by an independent monitor on the falling edge.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cnt_clr;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipeline_stall_ctrl_if bus();

    pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_clr  (cnt_clr),
        .bus      (bus),
        .state_o  (state_o),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [4:0]       en;    // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [2:0]       fl;    // {if_id, id_ex, mem_wb}
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        bit               regs;  // registered state is defined
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input string what, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", name, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "en", 16'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}), 16'(e.en));
            cmp(e.name, "flush", 16'({bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}), 16'(e.fl));
            if (e.regs) begin
                cmp(e.name, "state", 16'(state_o), 16'(e.st));
                cmp(e.name, "stall_cnt", 16'(stall_cnt), 16'(e.sc));
                cmp(e.name, "flush_cnt", 16'(flush_cnt), 16'(e.fc));
            end
        end
    end

    // inputs packed as {rst_n, lu, rd, im, dq, dr, clr}
    task automatic step(input string name, input logic [6:0] in,
                        input logic [4:0] en, input logic [2:0] fl, input logic [1:0] st,
                        input int sc, input int fc, input bit regs = 1'b1);
        exp_t e;
        rst_n              = in[6];
        bus.load_use_stall = in[5];
        bus.redirect_valid = in[4];
        bus.imem_ready     = in[3];
        bus.dmem_req       = in[2];
        bus.dmem_ready     = in[1];
        cnt_clr            = in[0];
        e.name = name; e.en = en; e.fl = fl; e.st = st;
        e.sc = CNT_W'(sc); e.fc = CNT_W'(fc); e.regs = regs;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] IDLE = 7'b1001000;
    localparam logic [4:0] EN_ALL = 5'b11111, EN_FRZ = 5'b00001, EN_LU = 5'b00111,
                           EN_DRN = 5'b01111, EN_RST = 5'b00000;
    localparam logic [2:0] FL_NONE = 3'b000, FL_RD = 3'b110, FL_IF = 3'b100,
                           FL_LU = 3'b010, FL_MW = 3'b001, FL_ALL = 3'b111;

    initial begin
        rst_n = 1'b0; cnt_clr = 1'b0;
        bus.load_use_stall = 1'b0; bus.redirect_valid = 1'b0; bus.imem_ready = 1'b1;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        @(posedge clk); #1;

        step("rst0", 7'b0001000, EN_RST, FL_ALL, 0, 0, 0, 1'b0);
        step("rst1", 7'b0001000, EN_RST, FL_ALL, 0, 0, 0);
        step("rst2", 7'b0001000, EN_RST, FL_ALL, 0, 0, 0);
        step("idle", IDLE,       EN_ALL, FL_NONE, 0, 0, 0);
        step("lu",   7'b1101000, EN_LU,  FL_LU,   0, 0, 0);
        step("clr",  7'b1001001, EN_ALL, FL_NONE, 0, 1, 0);
        step("frz0", 7'b1001100, EN_FRZ, FL_MW,   0, 0, 0);
        step("frz1", 7'b1001100, EN_FRZ, FL_MW,   1, 1, 0);
        step("frz2", 7'b1001100, EN_FRZ, FL_MW,   1, 2, 0);
        step("frz3", 7'b1001100, EN_FRZ, FL_MW,   1, 3, 0);
        step("dmok", 7'b1001110, EN_ALL, FL_NONE, 1, 4, 0);
        step("run",  IDLE,       EN_ALL, FL_NONE, 0, 4, 0);
        step("rd_noim", 7'b1010000, EN_ALL, FL_RD, 0, 4, 0);
        step("drain0",  7'b1000000, EN_DRN, FL_IF, 2, 4, 1);
        step("drain1",  7'b1001000, EN_DRN, FL_IF, 2, 5, 1);
        step("run2",    IDLE,       EN_ALL, FL_NONE, 0, 6, 1);
        step("collide", 7'b1111000, EN_ALL, FL_RD, 0, 6, 1);
        step("run3",    IDLE,       EN_ALL, FL_NONE, 0, 6, 2);
        step("noim",    7'b1000000, EN_DRN, FL_IF, 0, 6, 2);
        step("rd_a",    7'b1010000, EN_ALL, FL_RD, 0, 7, 2);
        step("frz_ret", 7'b1001100, EN_FRZ, FL_MW, 2, 7, 3);
        step("dmok2",   7'b1001110, EN_ALL, FL_NONE, 1, 8, 3);
        step("rd_b",    7'b1010000, EN_ALL, FL_RD, 0, 8, 3);
        step("frz_pend",7'b1000100, EN_FRZ, FL_MW, 2, 8, 4);
        step("drain2",  7'b1001000, EN_DRN, FL_IF, 2, 9, 4);
        step("frz_ign", 7'b1111100, EN_FRZ, FL_MW, 0, 10, 4);
        step("dwait",   IDLE,       EN_ALL, FL_NONE, 1, 11, 4);
        step("rd_c",    7'b1010000, EN_ALL, FL_RD, 0, 11, 4);
        step("rst_mid", 7'b0000000, EN_RST, FL_ALL, 2, 11, 5);
        step("post_rst",IDLE,       EN_ALL, FL_NONE, 0, 0, 0);

        for (int k = 0; k < 20; k++)
            step("stall_sat", 7'b1101000, EN_LU, FL_LU, 0, (k > 15) ? 15 : k, 0);
        step("sc_max",  IDLE,       EN_ALL, FL_NONE, 0, 15, 0);
        step("clr_stl", 7'b1101001, EN_LU,  FL_LU,   0, 15, 0);
        step("sc_zero", IDLE,       EN_ALL, FL_NONE, 0, 0, 0);

        for (int k = 0; k < 20; k++)
            step("flush_sat", 7'b1011000, EN_ALL, FL_RD, 0, 0, (k > 15) ? 15 : k);
        step("fc_max",  IDLE,       EN_ALL, FL_NONE, 0, 0, 15);
        step("clr_rd",  7'b1011001, EN_ALL, FL_RD,   0, 0, 15);
        step("fc_zero", IDLE,       EN_ALL, FL_NONE, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
